// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request controller.
// Issues word-aligned memory requests into a fetch FIFO, limits the number of
// requests in flight, keeps a stalled request stable until it is granted and
// drops responses that belong to fetches overtaken by a branch.

module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,

    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,

    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,

    output logic                busy_o
);

    // Counter widths: CW holds 0..NUM_REQS, SW holds the sum of two such values.
    localparam int unsigned     CW      = $clog2(NUM_REQS + 1);
    localparam int unsigned     SW      = CW + 1;
    localparam logic [CW-1:0]   MAX_OUT = CW'(NUM_REQS);
    localparam logic [SW-1:0]   LIMIT   = SW'(NUM_REQS);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(1'b0);

    // Number of occupied upper FIFO entries.
    function automatic logic [SW-1:0] popcount(input logic [NUM_REQS-1:0] vec);
        logic [SW-1:0] cnt;
        cnt = SW'(1'b0);
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cnt = cnt + SW'(vec[i]);
        end
        return cnt;
    endfunction

    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic          held_r;
    logic [31:0]   fetch_addr_r;

    logic [31:0]   branch_base_s;
    logic [SW-1:0] fill_s;
    logic          room_s;
    logic          fifo_room_s;
    logic          new_req_s;
    logic          req_s;
    logic          gnt_s;
    logic          fwd_s;
    logic [CW-1:0] outstanding_d_s;
    logic [CW-1:0] discard_d_s;
    logic [31:0]   fetch_addr_d_s;

    assign branch_base_s = {addr_i[31:2], 2'b00};
    assign fill_s        = popcount(fifo_busy_i) + {1'b0, outstanding_r};
    assign room_s        = (outstanding_r < MAX_OUT);
    assign fifo_room_s   = (fill_s < LIMIT);
    // A branch clears the FIFO, so its occupancy does not limit the redirect fetch.
    assign new_req_s     = req_i & room_s & (branch_i | fifo_room_s);

    // Request generation: a pending ungranted request stays up unless a branch replaces it.
    always_comb begin
        req_s = 1'b0;
        if (!rst_ni) begin
            req_s = 1'b0;
        end else if (branch_i) begin
            req_s = new_req_s;
        end else begin
            req_s = held_r | new_req_s;
        end
    end

    assign gnt_s = instr_gnt_i & req_s;
    // Responses of pre-branch fetches are dropped until the discard count drains.
    assign fwd_s = rst_ni & instr_rvalid_i & ~branch_i & (discard_r == CNT_ZERO);

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = fwd_s;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign instr_req_o  = req_s;
    assign instr_addr_o = branch_i ? branch_base_s : fetch_addr_r;
    assign busy_o       = (outstanding_r != CNT_ZERO) | req_s;

    // Next in-flight count: +1 per grant, -1 per response.
    always_comb begin
        outstanding_d_s = outstanding_r;
        case ({gnt_s, instr_rvalid_i})
            2'b10: outstanding_d_s = outstanding_r + CNT_ONE;
            2'b01: begin
                if (outstanding_r != CNT_ZERO) begin
                    outstanding_d_s = outstanding_r - CNT_ONE;
                end else begin
                    outstanding_d_s = CNT_ZERO;
                end
            end
            default: outstanding_d_s = outstanding_r;
        endcase
    end

    // Next discard count: captured at a branch, drained by dropped responses.
    always_comb begin
        discard_d_s = discard_r;
        if (branch_i) begin
            if (outstanding_r != CNT_ZERO) begin
                discard_d_s = outstanding_r - CW'(instr_rvalid_i);
            end else begin
                discard_d_s = CNT_ZERO;
            end
        end else if (instr_rvalid_i && (discard_r != CNT_ZERO)) begin
            discard_d_s = discard_r - CNT_ONE;
        end else begin
            discard_d_s = discard_r;
        end
    end

    // Next fetch address: redirect on branch, step one word per grant.
    always_comb begin
        fetch_addr_d_s = fetch_addr_r;
        if (branch_i) begin
            if (gnt_s) begin
                fetch_addr_d_s = branch_base_s + 32'd4;
            end else begin
                fetch_addr_d_s = branch_base_s;
            end
        end else if (gnt_s) begin
            fetch_addr_d_s = fetch_addr_r + 32'd4;
        end else begin
            fetch_addr_d_s = fetch_addr_r;
        end
    end

    // Control state: in-flight count, discard count and held-request flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            held_r        <= 1'b0;
        end else begin
            outstanding_r <= outstanding_d_s;
            discard_r     <= discard_d_s;
            held_r        <= req_s & ~instr_gnt_i;
        end
    end

    generate
        if (ResetAll) begin : g_addr_rst
            // Fetch address register with reset.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    fetch_addr_r <= 32'h0000_0000;
                end else begin
                    fetch_addr_r <= fetch_addr_d_s;
                end
            end
        end else begin : g_addr_norst
            // Fetch address register without reset; a branch always precedes use.
            always_ff @(posedge clk_i) begin
                fetch_addr_r <= fetch_addr_d_s;
            end
        end
    endgenerate

    ibex_fetch_req_ctrl_chk u_chk (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_req       (req_s),
        .instr_gnt       (instr_gnt_i),
        .instr_rvalid    (instr_rvalid_i),
        .outstanding_zero(outstanding_r == CNT_ZERO),
        .fifo_push       (fwd_s),
        .fifo_full       (fifo_busy_i[NUM_REQS-1]),
        .fifo_clear      (branch_i)
    );

endmodule

// Protocol checker for the fetch request controller.
module ibex_fetch_req_ctrl_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic instr_req,
    input logic instr_gnt,
    input logic instr_rvalid,
    input logic outstanding_zero,
    input logic fifo_push,
    input logic fifo_full,
    input logic fifo_clear
);

    a_rvalid_no_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid |-> !outstanding_zero);

    a_gnt_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_gnt |-> instr_req);

    a_push_into_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fifo_push && fifo_full) |-> fifo_clear);

endmodule
